bcd_fadd_1digit: RTL and testbench

//  Single-digit BCD full adder with registered outputs. Adds two BCD digits and a

---
 rtl/bcd_fadd_1digit_pkg.sv | 18 +
 rtl/bcd_fadd_1digit_fadd.sv | 11 +
 rtl/bcd_fadd_1digit.sv | 53 +++++
 tb/tb_bcd_fadd_1digit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/bcd_fadd_1digit_pkg.sv
// Shared constants and types for single- and multi-digit BCD adders.
package bcd_fadd_1digit_pkg;
  localparam int          BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_CORR = 4'd6;

  // Registered result of one digit slice
  typedef struct packed {
    logic             cout;
    logic [BCD_W-1:0] sum;
    logic             err;
  } bcd_res_t;

  // Binary sum (0..31) exceeds the largest decimal digit
  function automatic logic bcd_gt9(input logic [BCD_W:0] s);
    return s[4] | (s[3] & (s[2] | s[1]));
  endfunction
endpackage

// File: rtl/bcd_fadd_1digit_fadd.sv
// 1-bit binary full adder; the ripple cell of the digit adder.
module fadd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/bcd_fadd_1digit.sv
// Single-digit BCD full adder: binary ripple add, decimal correction,
// operand range flag, one register stage.
module bcd_fadd_1digit
  import bcd_fadd_1digit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout,
  output logic             err
);
  logic [BCD_W:0]   c;
  logic [BCD_W-1:0] s_lo;
  logic [BCD_W:0]   s;
  logic             corr;
  bcd_res_t         res_n, res_q;

  assign c[0] = cin;

  // Binary ripple a + b + cin; final carry becomes s[4]
  for (genvar i = 0; i < BCD_W; i++) begin : g_rip
    fadd u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s_lo[i]),
      .co (c[i+1])
    );
  end

  assign s    = {c[BCD_W], s_lo};
  assign corr = bcd_gt9(s);

  // Decimal correction: +6 wraps the low nibble past 9; carry is the compare result
  always_comb begin
    res_n.cout = corr;
    res_n.sum  = corr ? (s_lo + BCD_CORR) : s_lo;
    res_n.err  = (a > BCD_MAX) | (b > BCD_MAX);
  end

  // Output register with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_n;
  end

  assign sum  = res_q.sum;
  assign cout = res_q.cout;
  assign err  = res_q.err;
endmodule

// File: tb/tb_bcd_fadd_1digit.sv
// Bench for bcd_fadd_1digit: decimal reference model, per-cycle compare,
// directed literal cases, sweep, exhaustive and random stimulus, reset cases.
module tb_bcd_fadd_1digit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       cout, err;

  int total = 0;
  int bad   = 0;

  logic [5:0] mexp;
  logic       mvld = 1'b0;

  bcd_fadd_1digit dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: decimal digit addition from plain integer arithmetic -> {err,cout,sum}
  function automatic logic [5:0] model(input int x, input int y, input int c);
    int s, d, co;
    s  = x + y + c;
    co = (s > 9) ? 1 : 0;
    d  = co ? ((s + 6) % 16) : s;
    return {((x > 9) || (y > 9)) ? 1'b1 : 1'b0, co[0], 4'(d)};
  endfunction

  task automatic chk(input string nm, input logic [3:0] es, input logic ec, input logic ee);
    total++;
    if ({cout, sum, err} !== {ec, es, ee}) begin
      bad++;
      $display("FAIL %s: got sum=%0d cout=%0d err=%0d want sum=%0d cout=%0d err=%0d",
               nm, sum, cout, err, es, ec, ee);
    end
  endtask

  task automatic chkm(input string nm, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: model gives %b want %b", nm, got, want);
    end
  endtask

  // Capture the model expectation for the inputs seen at each edge
  always @(posedge clk) begin
    if (rst_n) begin
      mexp = model(a, b, cin);
      mvld = 1'b1;
    end else begin
      mvld = 1'b0;
    end
  end

  // Compare outputs every cycle, away from the edge
  always @(posedge clk) begin
    #2;
    if (!rst_n)    chk("reset_hold", 4'd0, 1'b0, 1'b0);
    else if (mvld) chk("model", mexp[3:0], mexp[4], mexp[5]);
  end

  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c;
  endtask

  task automatic directed(input string nm, input logic [3:0] x, input logic [3:0] y,
                          input logic c, input logic [3:0] es, input logic ec, input logic ee);
    drive(x, y, c);
    @(posedge clk); #2;
    chk(nm, es, ec, ee);
  endtask

  initial begin
    // Pin the model with hand-computed values
    chkm("m_9p0",   model(4, 5, 0),   {1'b0, 1'b0, 4'd9});
    chkm("m_10",    model(5, 5, 0),   {1'b0, 1'b1, 4'd0});
    chkm("m_19",    model(9, 9, 1),   {1'b0, 1'b1, 4'd9});
    chkm("m_31",    model(15, 15, 1), {1'b1, 1'b1, 4'd5});
    chkm("m_24",    model(12, 12, 0), {1'b1, 1'b1, 4'd14});

    // Reset with live non-zero inputs
    #1 rst_n = 1'b0;
    a = 4'd7; b = 4'd8; cin = 1'b1;
    #1 chk("reset_immediate", 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    directed("nocarry_4_5",  4'd4,  4'd5, 1'b0, 4'd9,  1'b0, 1'b0);
    directed("zero",         4'd0,  4'd0, 1'b0, 4'd0,  1'b0, 1'b0);
    directed("carry_5_5",    4'd5,  4'd5, 1'b0, 4'd0,  1'b1, 1'b0);
    directed("carry_8_8_1",  4'd8,  4'd8, 1'b1, 4'd7,  1'b1, 1'b0);
    directed("max_9_9_1",    4'd9,  4'd9, 1'b1, 4'd9,  1'b1, 1'b0);
    directed("inv_12_12",    4'd12, 4'd12,1'b0, 4'd14, 1'b1, 1'b1);
    directed("inv_10_0",     4'd10, 4'd0, 1'b0, 4'd0,  1'b1, 1'b1);
    directed("inv_15_15_1",  4'd15, 4'd15,1'b1, 4'd5,  1'b1, 1'b1);
    directed("s9_8_0_1",     4'd8,  4'd0, 1'b1, 4'd9,  1'b0, 1'b0);

    // Sweep a=b stepping by 2, cin toggling
    for (int k = 0; k < 32; k++) drive(4'((2 * k) % 16), 4'((2 * k) % 16), 1'(k % 2));

    // Exhaustive
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) drive(4'(x), 4'(y), 1'(c));

    // Mid-stream reset while cout=1
    directed("pre_rst_carry", 4'd6, 4'd7, 1'b0, 4'd3, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("midrst_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    a = 4'd8; b = 4'd8; cin = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("release_first", 4'd7, 1'b1, 1'b0);

    // Random stimulus with occasional reset pulses
    for (int k = 0; k < 400; k++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 chk("rand_rst", 4'd0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
      end
    end

    @(posedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
